// File: rtl/stack_seq_ctrl.sv
// Stack sequencer for CALL/RET/RTI/INT: splits PC and flags into stack words,
// owns the stack pointer and stalls the pipeline while words are moving.
module stack_seq_ctrl #(
    parameter int unsigned     PC_WORDS   = 2,
    parameter int unsigned     FLAG_WORDS = 1,
    parameter int unsigned     CNT_W      = 2,
    parameter int unsigned     SP_W       = 11,
    parameter logic [SP_W-1:0] SP_INIT    = {SP_W{1'b1}}
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic             mem_ready,
    output logic             busy,
    output logic             push,
    output logic             pop,
    output logic [SP_W-1:0]  mem_addr,
    output logic [CNT_W-1:0] word_sel,
    output logic [SP_W-1:0]  sp,
    output logic             done
);

    typedef enum logic [0:0] {StIdle, StXfer} state_e;

    // Word counts carry one extra bit so N = 2**CNT_W stays representable.
    localparam logic [CNT_W:0] NShort = (CNT_W+1)'(PC_WORDS);
    localparam logic [CNT_W:0] NLong  = (CNT_W+1)'(PC_WORDS + FLAG_WORDS);
    localparam logic [CNT_W:0] CntOne = (CNT_W+1)'(1);
    localparam logic [SP_W-1:0] SpOne = SP_W'(1);

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  idx_q, idx_d;
    logic [1:0]        op_q, op_d;
    logic [SP_W-1:0]   sp_q, sp_d;
    logic              done_q, done_d;

    logic              is_push;
    logic              last_word;
    logic [CNT_W:0]    n_words;
    logic [CNT_W:0]    rev_sel;

    // Decode of the latched op: word count, direction and last-word flag.
    always_comb begin
        n_words   = op_q[1] ? NLong : NShort;
        // CALL (00) and INT (11) push; RET (01) and RTI (10) pop.
        is_push   = (op_q[0] == op_q[1]);
        last_word = ({1'b0, idx_q} == (n_words - CntOne));
        rev_sel   = n_words - CntOne - {1'b0, idx_q};
    end

    // Outputs decoded from registered state only.
    always_comb begin
        busy     = (state_q == StXfer);
        push     = (state_q == StXfer) && is_push;
        pop      = (state_q == StXfer) && !is_push;
        // Pops walk the fields in reverse so a pop sequence undoes a push sequence.
        word_sel = is_push ? idx_q : rev_sel[CNT_W-1:0];
        mem_addr = is_push ? sp_q : sp_q + SpOne;
        sp       = sp_q;
        done     = done_q;
    end

    // Next-state logic: accept start in IDLE, step one word per ready cycle in XFER.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        op_d    = op_q;
        sp_d    = sp_q;
        done_d  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    op_d    = op;
                    idx_d   = '0;
                    state_d = StXfer;
                end
            end
            StXfer: begin
                if (mem_ready) begin
                    sp_d  = is_push ? sp_q - SpOne : sp_q + SpOne;
                    idx_d = idx_q + CNT_W'(1);
                    if (last_word) begin
                        state_d = StIdle;
                        done_d  = 1'b1;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= StIdle;
            idx_q   <= '0;
            op_q    <= 2'b00;
            sp_q    <= SP_INIT;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            op_q    <= op_d;
            sp_q    <= sp_d;
            done_q  <= done_d;
        end
    end

endmodule

// File: tb/tb_stack_seq_ctrl.sv
// Self-checking bench for stack_seq_ctrl: queue-based reference model compared
// every cycle, directed scenarios pinned with literal values, then random traffic.
module tb_stack_seq_ctrl;

    localparam int unsigned SP_W  = 11;
    localparam int unsigned CNT_W = 2;

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic             start = 1'b0;
    logic [1:0]       op = 2'b00;
    logic             mem_ready = 1'b0;
    logic             busy, push, pop, done;
    logic [SP_W-1:0]  mem_addr, sp;
    logic [CNT_W-1:0] word_sel;

    stack_seq_ctrl dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .op        (op),
        .mem_ready (mem_ready),
        .busy      (busy),
        .push      (push),
        .pop       (pop),
        .mem_addr  (mem_addr),
        .word_sel  (word_sel),
        .sp        (sp),
        .done      (done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [10:0] addr;
        logic [1:0]  sel;
        logic        is_push;
    } word_t;

    word_t       mq[$];      // words still to transfer in the current sequence
    word_t       wlog[$];    // words the model saw accepted
    word_t       w_acc;
    logic [10:0] m_sp = 11'h7FF;
    logic        m_done = 1'b0;
    bit          armed = 1'b0;
    int          n_cmp = 0;
    int          n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Expand an operation into its word list from the current model stack pointer.
    task automatic build(input logic [1:0] o);
        int n;
        bit psh;
        word_t w;
        n   = o[1] ? 3 : 2;
        psh = (o[0] == o[1]);
        for (int i = 0; i < n; i++) begin
            w.is_push = psh;
            if (psh) begin
                w.addr = m_sp - 11'(i);
                w.sel  = 2'(i);
            end else begin
                w.addr = m_sp + 11'(i + 1);
                w.sel  = 2'(n - 1 - i);
            end
            mq.push_back(w);
        end
    endtask

    // Compare DUT against model, then advance the model using the inputs the next edge samples.
    initial forever begin
        @(negedge clk);
        if (armed) begin
            chk("busy", 32'(busy), 32'(mq.size() > 0));
            chk("push", 32'(push), 32'(mq.size() > 0 && mq[0].is_push));
            chk("pop",  32'(pop),  32'(mq.size() > 0 && !mq[0].is_push));
            chk("done", 32'(done), 32'(m_done));
            chk("sp",   32'(sp),   32'(m_sp));
            if (mq.size() > 0) begin
                chk("mem_addr", 32'(mem_addr), 32'(mq[0].addr));
                chk("word_sel", 32'(word_sel), 32'(mq[0].sel));
            end
        end
        if (!reset) begin
            mq.delete();
            m_sp   = 11'h7FF;
            m_done = 1'b0;
        end else begin
            m_done = 1'b0;
            if (mq.size() > 0) begin
                if (mem_ready) begin
                    w_acc = mq.pop_front();
                    wlog.push_back(w_acc);
                    m_sp = w_acc.is_push ? m_sp - 11'd1 : m_sp + 11'd1;
                    if (mq.size() == 0) m_done = 1'b1;
                end
            end else if (start) begin
                build(op);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_word(input string tag, input int i, input logic [10:0] a,
                            input logic [1:0] s);
        if (i < wlog.size()) begin
            chk({tag, "_addr"}, 32'(wlog[i].addr), 32'(a));
            chk({tag, "_sel"},  32'(wlog[i].sel),  32'(s));
        end else begin
            chk({tag, "_missing"}, 32'(wlog.size()), 32'(i + 1));
        end
    endtask

    // One sequence: start, then drive mem_ready from pat (1 once exhausted) until idle.
    task automatic run_op(input logic [1:0] o, input int plen, input logic [7:0] pat,
                          output int nbusy);
        int k;
        int guard;
        k = 0;
        guard = 0;
        wlog.delete();
        start = 1'b1;
        op = o;
        mem_ready = 1'b1;
        tick();
        start = 1'b0;
        op = 2'($urandom);
        nbusy = 0;
        while (mq.size() > 0 && guard < 64) begin
            mem_ready = (k < plen) ? pat[k] : 1'b1;
            k++;
            nbusy++;
            guard++;
            tick();
        end
        if (guard >= 64) chk("seq_timeout", 32'(mq.size()), 32'd0);
        chk("done_pulse", 32'(done), 32'd1);
        mem_ready = 1'b0;
        tick();
    endtask

    initial begin
        int nb;
        reset = 1'b0;
        tick();
        tick();
        armed = 1'b1;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_sp",   32'(sp),   32'h7FF);
        reset = 1'b1;
        tick();

        // CALL, no wait states.
        run_op(2'b00, 0, 8'h00, nb);
        chk("call_busy_cycles", 32'(nb), 32'd2);
        chk_word("call_w0", 0, 11'h7FF, 2'd0);
        chk_word("call_w1", 1, 11'h7FE, 2'd1);
        chk("call_sp", 32'(sp), 32'h7FD);
        chk("call_msp", 32'(m_sp), 32'h7FD);

        // RET with mem_ready 0,1,0,0,1.
        run_op(2'b01, 5, 8'b0001_0010, nb);
        chk("ret_busy_cycles", 32'(nb), 32'd5);
        chk_word("ret_w0", 0, 11'h7FE, 2'd1);
        chk_word("ret_w1", 1, 11'h7FF, 2'd0);
        chk("ret_sp", 32'(sp), 32'h7FF);

        // INT then RTI round trip.
        run_op(2'b11, 0, 8'h00, nb);
        chk("int_busy_cycles", 32'(nb), 32'd3);
        chk_word("int_w0", 0, 11'h7FF, 2'd0);
        chk_word("int_w1", 1, 11'h7FE, 2'd1);
        chk_word("int_w2", 2, 11'h7FD, 2'd2);
        run_op(2'b10, 0, 8'h00, nb);
        chk_word("rti_w0", 0, 11'h7FD, 2'd2);
        chk_word("rti_w1", 1, 11'h7FE, 2'd1);
        chk_word("rti_w2", 2, 11'h7FF, 2'd0);
        chk("rti_sp", 32'(sp), 32'h7FF);

        // Wrap-around: RET from all-ones lands sp on 0x001, then CALL wraps back.
        run_op(2'b01, 0, 8'h00, nb);
        chk_word("wrap_ret_w0", 0, 11'h000, 2'd1);
        chk_word("wrap_ret_w1", 1, 11'h001, 2'd0);
        chk("wrap_ret_sp", 32'(sp), 32'h001);
        run_op(2'b00, 0, 8'h00, nb);
        chk_word("wrap_call_w0", 0, 11'h001, 2'd0);
        chk_word("wrap_call_w1", 1, 11'h000, 2'd1);
        chk("wrap_call_sp", 32'(sp), 32'h7FF);

        // Reset during the second word of INT.
        start = 1'b1;
        op = 2'b11;
        mem_ready = 1'b1;
        tick();
        start = 1'b0;
        tick();
        chk("mid_w1_addr", 32'(mem_addr), 32'h7FE);
        chk("mid_w1_sel",  32'(word_sel), 32'd1);
        reset = 1'b0;
        tick();
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_push", 32'(push), 32'd0);
        chk("mid_rst_done", 32'(done), 32'd0);
        chk("mid_rst_sp",   32'(sp),   32'h7FF);
        reset = 1'b1;
        tick();
        chk("mid_post_done0", 32'(done), 32'd0);
        tick();
        chk("mid_post_done1", 32'(done), 32'd0);

        // start held high across a whole CALL: extra starts ignored, done-cycle start taken.
        wlog.delete();
        start = 1'b1;
        op = 2'b00;
        mem_ready = 1'b1;
        tick();
        chk("hold_busy0", 32'(busy), 32'd1);
        tick();
        chk("hold_busy1", 32'(busy), 32'd1);
        tick();
        chk("hold_done",  32'(done), 32'd1);
        chk("hold_idle",  32'(busy), 32'd0);
        tick();
        chk("hold_rebusy", 32'(busy), 32'd1);
        chk("hold_repush", 32'(push), 32'd1);
        start = 1'b0;
        tick();
        tick();
        chk("hold_done2", 32'(done), 32'd1);
        chk("hold_nwords", 32'(wlog.size()), 32'd4);
        chk_word("hold_w2", 2, 11'h7FD, 2'd0);
        chk_word("hold_w3", 3, 11'h7FC, 2'd1);
        chk("hold_sp", 32'(sp), 32'h7FB);

        // Random traffic with occasional resets.
        repeat (600) begin
            start     = ($urandom_range(0, 3) == 0);
            op        = 2'($urandom);
            mem_ready = ($urandom_range(0, 3) != 0);
            reset     = ($urandom_range(0, 80) != 0);
            tick();
        end
        start = 1'b0;
        reset = 1'b1;
        mem_ready = 1'b1;
        repeat (8) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
